// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares one IO bus between two masters. Request/acknowledge
// handshake, round-robin fairness on ties, and a completion timeout that
// returns an error acknowledge when the downstream never signals io_done.
module io_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [3:0]        m0_mode,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [3:0]        m1_mode,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [3:0]        io_mode,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_done,
    output logic [1:0]        grant
);
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t            r_state;
    logic [3:0]        r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_grant;
    logic              r_last_m1;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err0;
    logic              r_err1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_valid0;
    logic              w_valid1;
    logic              w_pick1;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_timeout;

    // Request qualification and winner selection. A master whose ack is
    // showing this cycle is still holding req for the access that just
    // finished, so it is not treated as a fresh request until ack drops.
    always_comb begin
        w_valid0  = m0_req && (m0_mode != 4'd0) && !r_ack0;
        w_valid1  = m1_req && (m1_mode != 4'd0) && !r_ack1;
        w_pick1   = w_valid1 && (!w_valid0 || !r_last_m1);
        w_cnt_inc = r_cnt + CNT_W'(1);
        w_timeout = (w_cnt_inc == CNT_MAX);
    end

    // Arbitration FSM: grant and latch in IDLE, hold the bus in ACCESS,
    // finish on io_done (which beats a coincident timeout) or on timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_grant   <= 2'b00;
            r_last_m1 <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_valid0 || w_valid1) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= '0;
                        r_grant <= w_pick1 ? 2'b10 : 2'b01;
                        r_mode  <= w_pick1 ? m1_mode  : m0_mode;
                        r_addr  <= w_pick1 ? m1_addr  : m0_addr;
                        r_wdata <= w_pick1 ? m1_wdata : m0_wdata;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= w_cnt_inc;
                    if (io_done || w_timeout) begin
                        r_state   <= S_IDLE;
                        r_grant   <= 2'b00;
                        r_mode    <= 4'd0;
                        r_last_m1 <= r_grant[1];
                        if (r_grant[1]) begin
                            r_ack1   <= 1'b1;
                            r_err1   <= !io_done;
                            r_rdata1 <= io_done ? io_rdata : '0;
                        end else begin
                            r_ack0   <= 1'b1;
                            r_err0   <= !io_done;
                            r_rdata0 <= io_done ? io_rdata : '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m0_ack   = r_ack0;
    assign m0_err   = r_err0;
    assign m0_rdata = r_rdata0;
    assign m1_ack   = r_ack1;
    assign m1_err   = r_err1;
    assign m1_rdata = r_rdata1;
    assign io_mode  = r_mode;
    assign io_addr  = r_addr;
    assign io_wdata = r_wdata;
    assign grant    = r_grant;

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
Two-requester arbiter that shares the single IO bus (io_mode/io_addr/io_wdata/io_rdata) between masters, e.g. CPU and a DMA/debug engine. Adds a request/acknowledge handshake, round-robin fairness, and a completion timeout. Sits between the masters and the memory/peripheral decoder; the downstream side signals completion with io_done.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max ACCESS cycles without io_done before error (1..65535)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
m0_req  in  1  master 0 request, held until m0_ack
m0_mode  in  4  master 0 IO mode; 0 = no operation
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  one-cycle timeout pulse, coincident with m0_ack
m0_rdata  out  DATA_W  read data, valid from m0_ack until next m0_ack
m1_req, m1_mode, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as master 0
io_mode  out  4  bus mode; 0 when idle
io_addr  out  ADDR_W  bus address
io_wdata  out  DATA_W  bus write data
io_rdata  in  DATA_W  bus read data, sampled when io_done=1
io_done  in  1  downstream completion strobe
grant  out  2  one-hot owner during ACCESS, 00 in IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; latched mode/addr/wdata 0; counter 0; last-served pointer = m1, so m0 wins the first tie. An access in flight is abandoned without ack and io_mode drops to 0 immediately.
- Valid request: mX_req=1 and mX_mode!=0. A request with mode 0 is ignored.
- IDLE: io_mode=0, grant=00. On a clock edge with at least one valid request, select the winner. With one valid request, that master wins. With two, the master not last served wins. Latch winner's mode/addr/wdata, set grant, clear counter, go to ACCESS.
- ACCESS: io_mode/io_addr/io_wdata driven from the latched registers, stable for the whole access, independent of later master input changes. Counter increments each cycle.
  - io_done=1 at an edge: capture io_rdata into the owner's rdata; owner's ack=1 on the next cycle for one cycle; update last-served pointer; go to IDLE.
  - Counter reaches TIMEOUT with io_done=0: owner's ack=1 and err=1 for one cycle; owner's rdata=0; pointer updated; go to IDLE.
  - io_done and timeout on the same edge: io_done wins, no err.
- Latency: request sampled at edge E0; bus driven from E0 until the io_done edge Ek (k>=1); ack high in cycle after Ek. At least one IDLE cycle separates accesses.
- Dropping mX_req during ACCESS does not abort. The access completes and still acks.
- io_done in IDLE is ignored.
- m0 and m1 acks are never asserted in the same cycle. Non-owner rdata is unchanged.
- Writes: the arbiter does not modify rdata beyond the capture rule. Downstream defines io_rdata for writes.
- Counter width: clog2(TIMEOUT+1). No wrap, because the counter stops at TIMEOUT.

Test Plan:
- Reset mid-access: m0 read addr 0x80000000 in ACCESS, pull rst low -> io_mode=0 and grant=00 at once; no m0_ack after release; next m0 request served normally.
- Single read: m0 mode=read addr 0x80000010, io_done 3 cycles later with io_rdata 0xDEADBEEF -> io_addr 0x80000010 held until done; m0_ack for 1 cycle with m0_rdata=0xDEADBEEF; m0_err=0.
- Tie after reset: m0 and m1 requesting in the same cycle -> m0 granted first, m1 next; a third simultaneous tie goes to m0 again (alternation).
- Input change mid-access: m1 write addr 0x10000000 data 0x55; m1 changes addr/wdata during ACCESS -> io_addr/io_wdata stay 0x10000000/0x55.
- Timeout: TIMEOUT=4, io_done held 0 -> m1_ack=m1_err=1 exactly one cycle after 4 ACCESS cycles; m1_rdata=0; return to IDLE.
- Ignored inputs: io_done pulse in IDLE with no request -> no ack, no state change; m0_req=1 with mode 0 -> never granted.
